// File: rtl/spi_slave_regbank.sv
// SPI mode-0 responder with a byte-wide register bank, fully oversampled in the clk_i domain.
// Frame: {RW, A[6:0]} then data bytes, MSB first; address auto-increments per data byte.
module spi_slave_regbank #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       spi_sck_i,
  input  logic                       spi_csn_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o,
  output logic                       spi_miso_oe_o,
  output logic [8*(2**ADDR_W)-1:0]   regs_o,
  output logic                       wr_valid_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic [7:0]                 wr_data_o,
  output logic                       rd_valid_o
);

  localparam int NREGS = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic                   sck_d, csn_d;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_rise, sck_fall, csn_fall;
  logic [2:0]             bit_cnt;
  logic [6:0]             rx_sr;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_sr;
  logic [ADDR_W-1:0]      addr, addr_inc, fetch_addr;
  logic [7:0]             regs [NREGS];
  logic                   active, byte_done;
  logic                   load_cmd, do_write, do_fetch;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_fall = ~csn_s & csn_d;

  // Deselect is checked first, so edges seen while csn is high never touch the datapath.
  assign active    = (state != IDLE) && !csn_s;
  assign byte_done = active && sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, mosi_s};
  assign addr_inc  = addr + ADDR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    load_cmd   = 1'b0;
    do_write   = 1'b0;
    do_fetch   = 1'b0;
    fetch_addr = addr_inc;
    if (state != IDLE && csn_s) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:  if (csn_fall) next_state = CMD;
        CMD: begin
          if (byte_done) begin
            next_state = rx_byte[7] ? RDATA : WDATA;
            load_cmd   = 1'b1;
            do_fetch   = rx_byte[7];
            fetch_addr = rx_byte[ADDR_W-1:0];
          end
        end
        WDATA: do_write = byte_done;
        RDATA: do_fetch = byte_done;
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_sync      <= '0;
      // csn idles high, so its synchronizer resets deselected to keep OE quiet out of reset.
      csn_sync      <= '1;
      mosi_sync     <= '0;
      sck_d         <= 1'b0;
      csn_d         <= 1'b1;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      addr          <= '0;
      spi_miso_o    <= 1'b0;
      spi_miso_oe_o <= 1'b0;
      wr_valid_o    <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      rd_valid_o    <= 1'b0;
      // NOTE: the bank is a reset flop array, not RAM, because reset must clear every register.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      sck_sync      <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      csn_sync      <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_d         <= sck_s;
      csn_d         <= csn_s;
      spi_miso_oe_o <= ~csn_s;
      wr_valid_o    <= 1'b0;
      rd_valid_o    <= 1'b0;

      if (wr_valid_o) regs[wr_addr_o] <= wr_data_o;

      if (state == IDLE && csn_fall) begin
        bit_cnt <= '0;
        tx_sr   <= '0;
      end else if (active && sck_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (csn_s) begin
        spi_miso_o <= 1'b0;
      end else if (active && sck_fall) begin
        spi_miso_o <= tx_sr[7];
        tx_sr      <= {tx_sr[6:0], 1'b0};
      end

      if (load_cmd) addr <= rx_byte[ADDR_W-1:0];

      if (do_write) begin
        wr_valid_o <= 1'b1;
        wr_addr_o  <= addr;
        wr_data_o  <= rx_byte;
        addr       <= addr_inc;
      end

      // Prefetch lands on a rise; the shift above only runs on falls, so they never collide.
      if (do_fetch) begin
        tx_sr      <= regs[fetch_addr];
        rd_valid_o <= 1'b1;
        if (!load_cmd) addr <= addr_inc;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_o[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Directed bench for spi_slave_regbank: a bit-banged SPI master issues frames and queues
// expected writes, prefetches and MISO bytes; a monitor pops and compares as the DUT responds.
`timescale 1ns/1ps
module tb_spi_slave_regbank;

  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         csn = 1'b1;
  logic         mosi = 1'b0;
  logic         miso, miso_oe, wr_valid, rd_valid;
  logic [127:0] regs;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;

  always #5 clk = ~clk;

  spi_slave_regbank #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_csn_i(csn), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe), .regs_o(regs),
    .wr_valid_o(wr_valid), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .rd_valid_o(rd_valid)
  );

  typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  wr_t        exp_wr[$];
  int         exp_rd[$];
  logic [7:0] exp_miso[$];
  logic [7:0] got_miso[$];
  logic [7:0] model [NREGS];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = model[i];
    return v;
  endfunction

  task automatic expect_wr(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  // MISO is captured just before each rising SCK, where a mode-0 master samples it.
  task automatic spi_bits(input logic [7:0] data, input int nbits, output logic [7:0] cap);
    cap = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = data[i];
      clks(4);
      cap  = {cap[6:0], miso};
      sck  = 1'b1;
      clks(4);
      sck  = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input int n);
    logic [7:0] bytes [3];
    logic [7:0] cap;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    csn = 1'b0;
    clks(8);
    check("miso_oe while selected", miso_oe, 1'b1);
    for (int i = 0; i < n; i++) begin
      spi_bits(bytes[i], 8, cap);
      got_miso.push_back(cap);
    end
    clks(4);
    csn = 1'b1;
    clks(10);
    check("miso_oe after deselect", miso_oe, 1'b0);
    check("miso after deselect", miso, 1'b0);
  endtask

  task automatic expect_miso(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int n);
    if (n > 0) exp_miso.push_back(b0);
    if (n > 1) exp_miso.push_back(b1);
    if (n > 2) exp_miso.push_back(b2);
  endtask

  task automatic expect_rd(input int n);
    for (int i = 0; i < n; i++) exp_rd.push_back(i);
  endtask

  // Monitor: pops expectations whenever the DUT pulses or a MISO byte has been captured.
  initial begin
    wr_t        e;
    logic [7:0] g;
    forever begin
      @(negedge clk);
      if (wr_valid === 1'b1) begin
        check("wr_valid expected", exp_wr.size() > 0, 1'b1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
      end
      if (rd_valid === 1'b1) begin
        check("rd_valid expected", exp_rd.size() > 0, 1'b1);
        if (exp_rd.size() > 0) void'(exp_rd.pop_front());
      end
      while (got_miso.size() > 0) begin
        g = got_miso.pop_front();
        check("miso byte expected", exp_miso.size() > 0, 1'b1);
        if (exp_miso.size() > 0) check("miso byte", g, exp_miso.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] cap;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(4);
    check("reset regs", regs, 128'h0);
    check("reset miso_oe", miso_oe, 1'b0);
    check("reset miso", miso, 1'b0);
    check("reset wr_valid", wr_valid, 1'b0);
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset wr_addr", wr_addr, 4'h0);
    check("reset wr_data", wr_data, 8'h00);

    // Write burst to regs 2,3
    expect_wr(4'h2, 8'hA5);
    expect_wr(4'h3, 8'h3C);
    expect_miso(8'h00, 8'h00, 8'h00, 3);
    frame(8'h02, 8'hA5, 8'h3C, 3);
    model[2] = 8'hA5;
    model[3] = 8'h3C;
    check("reg2 after write", regs[23:16], 8'hA5);
    check("reg3 after write", regs[31:24], 8'h3C);
    check("bank after burst", regs, model_vec());

    // Read burst: byte0 returns 0, then the two registers; one prefetch per byte
    expect_rd(3);
    expect_miso(8'h00, 8'hA5, 8'h3C, 3);
    frame(8'h82, 8'h00, 8'h00, 3);

    // Address wrap 15 -> 0 on write and read
    expect_wr(4'hF, 8'h11);
    expect_wr(4'h0, 8'h22);
    expect_miso(8'h00, 8'h00, 8'h00, 3);
    frame(8'h0F, 8'h11, 8'h22, 3);
    model[15] = 8'h11;
    model[0]  = 8'h22;
    check("bank after wrap write", regs, model_vec());
    expect_rd(3);
    expect_miso(8'h00, 8'h11, 8'h22, 3);
    frame(8'h8F, 8'h00, 8'h00, 3);

    // Upper address bits ignored: 0x73 hits reg3, 0xF3 reads it back
    expect_wr(4'h3, 8'h99);
    expect_miso(8'h00, 8'h00, 8'h00, 2);
    frame(8'h73, 8'h99, 8'h00, 2);
    model[3] = 8'h99;
    expect_rd(2);
    expect_miso(8'h00, 8'h99, 8'h00, 2);
    frame(8'hF3, 8'h00, 8'h00, 2);

    // Partial byte abort leaves reg5 at its old value
    expect_wr(4'h5, 8'h5A);
    expect_miso(8'h00, 8'h00, 8'h00, 2);
    frame(8'h05, 8'h5A, 8'h00, 2);
    model[5] = 8'h5A;
    csn = 1'b0;
    clks(8);
    spi_bits(8'h05, 8, cap);
    got_miso.push_back(cap);
    exp_miso.push_back(8'h00);
    spi_bits(8'hFF, 5, cap);
    clks(4);
    csn = 1'b1;
    clks(10);
    check("bank after abort", regs, model_vec());
    expect_rd(2);
    expect_miso(8'h00, 8'h5A, 8'h00, 2);
    frame(8'h85, 8'h00, 8'h00, 2);

    // Reset during the 2nd data bit of a write frame
    csn = 1'b0;
    clks(8);
    spi_bits(8'h06, 8, cap);
    spi_bits(8'hC0, 1, cap);
    mosi = 1'b1;
    clks(4);
    sck = 1'b1;
    clks(2);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(2);
    sck = 1'b0;
    clks(4);
    csn = 1'b1;
    clks(10);
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    check("bank after mid-frame reset", regs, 128'h0);
    check("miso_oe after mid-frame reset", miso_oe, 1'b0);

    // Clean frames after reset
    expect_wr(4'h1, 8'h77);
    expect_miso(8'h00, 8'h00, 8'h00, 2);
    frame(8'h01, 8'h77, 8'h00, 2);
    model[1] = 8'h77;
    check("bank after recovery write", regs, model_vec());
    expect_rd(2);
    expect_miso(8'h00, 8'h77, 8'h00, 2);
    frame(8'h81, 8'h00, 8'h00, 2);

    clks(20);
    check("pending write expectations", exp_wr.size(), 0);
    check("pending prefetch expectations", exp_rd.size(), 0);
    check("pending miso expectations", exp_miso.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
